// File: rtl/lb_pkg.sv
//------------------------------------------------------------------------------
// lb_pkg : shared lane-vector types and constants for the input vector FIFO
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lb_pkg;
   localparam int LB_N          = 8;
   localparam int LB_DATA_WIDTH = 32;
   localparam int DROP_CNT_W    = 16;

   typedef logic [LB_DATA_WIDTH-1:0] lane_vec_t [LB_N];

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

`default_nettype wire

// File: rtl/fifo_ctrl.sv
//------------------------------------------------------------------------------
// fifo_ctrl : pointers, occupancy, handshake flags and drop accounting
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_ctrl
   import lb_pkg::*;
#(
   parameter  int DEPTH    = 4,
   parameter  int AF_LEVEL = DEPTH - 1,
   localparam int PW       = $clog2(DEPTH),
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  valid_in,
   input  logic                  next_in,
   input  logic                  clear_in,
   output logic                  wr_en,
   output logic [PW-1:0]         head,
   output logic [PW-1:0]         tail,
   output logic [CW-1:0]         count,
   output logic                  ready,
   output logic                  valid,
   output logic                  almost_full,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   // Fullness is judged before the edge, so a same-edge pop never frees room for a push.
   assign push  = valid_in & ~full;
   assign pop   = next_in & ~empty;
   assign drop  = valid_in & full;

   assign wr_en       = push & ~clear_in;
   assign ready       = ~full;
   assign valid       = ~empty;
   assign almost_full = (int'(count) >= AF_LEVEL);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_in) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) head <= head + 1'b1;
         if (pop)  tail <= tail + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc(drop_count);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/input_vector_fifo.sv
//------------------------------------------------------------------------------
// input_vector_fifo : show-ahead FIFO of N-lane vectors with eof tags
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module input_vector_fifo
   import lb_pkg::*;
#(
   parameter int N          = LB_N,
   parameter int DATA_WIDTH = LB_DATA_WIDTH,
   parameter int IB_DEPTH   = 4,
   parameter int AF_LEVEL   = IB_DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          valid_in,
   input  logic                          eof_in,
   input  logic [DATA_WIDTH-1:0]         vector_in [N],
   output logic                          ready_out,
   input  logic                          next_in,
   input  logic                          clear_in,
   output logic                          valid_out,
   output logic                          eof_out,
   output logic [DATA_WIDTH-1:0]         vector_out [N],
   output logic [$clog2(IB_DEPTH+1)-1:0] count_out,
   output logic                          almost_full,
   output logic                          overflow,
   output logic [DROP_CNT_W-1:0]         drop_count
);

   localparam int PW = $clog2(IB_DEPTH);

   logic                  wr_en;
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [DATA_WIDTH-1:0] mem     [IB_DEPTH][N];
   logic                  eof_mem [IB_DEPTH];

   fifo_ctrl #(
      .DEPTH    (IB_DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) u_ctrl (
      .clk         (clk),
      .resetn      (resetn),
      .valid_in    (valid_in),
      .next_in     (next_in),
      .clear_in    (clear_in),
      .wr_en       (wr_en),
      .head        (head),
      .tail        (tail),
      .count       (count_out),
      .ready       (ready_out),
      .valid       (valid_out),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   // Payload storage carries no reset; validity is tracked by the control state alone.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < N; i++) mem[head][i] <= vector_in[i];
         eof_mem[head] <= eof_in;
      end
   end

   assign eof_out = eof_mem[tail];

   for (genvar g = 0; g < N; g++) begin : g_lane
      assign vector_out[g] = mem[tail][g];
   end

endmodule

`default_nettype wire

// File: tb/tb_input_vector_fifo.sv
//------------------------------------------------------------------------------
// tb_input_vector_fifo : table vectors, corner sequences and random traffic vs a queue model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_input_vector_fifo;
   localparam int N     = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          valid_in = 1'b0;
   logic          eof_in = 1'b0;
   logic [DW-1:0] vector_in [N];
   logic          ready_out;
   logic          next_in = 1'b0;
   logic          clear_in = 1'b0;
   logic          valid_out;
   logic          eof_out;
   logic [DW-1:0] vector_out [N];
   logic [2:0]    count_out;
   logic          almost_full;
   logic          overflow;
   logic [15:0]   drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of lane seeds plus eof tags
   int unsigned q_seed[$];
   bit          q_eof[$];
   bit          m_ovf;
   int          m_drop;

   always #5 clk = ~clk;

   input_vector_fifo #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .valid_in    (valid_in),
      .eof_in      (eof_in),
      .vector_in   (vector_in),
      .ready_out   (ready_out),
      .next_in     (next_in),
      .clear_in    (clear_in),
      .valid_out   (valid_out),
      .eof_out     (eof_out),
      .vector_out  (vector_out),
      .count_out   (count_out),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   function automatic logic [DW-1:0] lane_val(input int unsigned seed, input int i);
      return seed + i * 32'h0101_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q_seed.delete();
      q_eof.delete();
      m_ovf  = 0;
      m_drop = 0;
   endtask

   task automatic check_model();
      chk("count", 64'(count_out), 64'(q_seed.size()));
      chk("valid", 64'(valid_out), 64'(q_seed.size() > 0));
      chk("ready", 64'(ready_out), 64'(q_seed.size() < DEPTH));
      chk("almost_full", 64'(almost_full), 64'(q_seed.size() >= DEPTH - 1));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (q_seed.size() > 0) begin
         chk("eof_out", 64'(eof_out), 64'(q_eof[0]));
         for (int i = 0; i < N; i++)
            chk("vector_out", 64'(vector_out[i]), 64'(lane_val(q_seed[0], i)));
      end
   endtask

   // Drive one cycle of stimulus, advance the model across the edge, check at the falling edge.
   task automatic cycle(input bit v, input bit e, input int unsigned seed, input bit nx, input bit clr);
      int sz;
      valid_in = v;
      eof_in   = e;
      next_in  = nx;
      clear_in = clr;
      for (int i = 0; i < N; i++) vector_in[i] = lane_val(seed, i);
      @(posedge clk);
      sz = q_seed.size();
      if (clr) begin
         model_reset();
      end else begin
         if (nx && sz > 0) begin
            void'(q_seed.pop_front());
            void'(q_eof.pop_front());
         end
         if (v && sz < DEPTH) begin
            q_seed.push_back(seed);
            q_eof.push_back(e);
         end else if (v) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
         end
      end
      @(negedge clk);
      valid_in = 0;
      next_in  = 0;
      clear_in = 0;
      check_model();
   endtask

   typedef struct {
      bit          v;
      bit          e;
      int unsigned seed;
      bit          nx;
      int          exp_count;
      bit          exp_valid;
      bit          exp_ovf;
      int          exp_drop;
   } vec_t;

   vec_t tbl[12];

   initial begin
      for (int i = 0; i < N; i++) vector_in[i] = '0;
      model_reset();

      // Fill, overflow for three cycles, full push+pop, then drain.
      tbl[0]  = '{1, 0, 1,  0, 1, 1, 0, 0};
      tbl[1]  = '{1, 0, 2,  0, 2, 1, 0, 0};
      tbl[2]  = '{1, 0, 3,  0, 3, 1, 0, 0};
      tbl[3]  = '{1, 1, 4,  0, 4, 1, 0, 0};
      tbl[4]  = '{1, 0, 99, 0, 4, 1, 1, 1};
      tbl[5]  = '{1, 1, 99, 0, 4, 1, 1, 2};
      tbl[6]  = '{1, 0, 99, 0, 4, 1, 1, 3};
      tbl[7]  = '{1, 0, 98, 1, 3, 1, 1, 4};
      tbl[8]  = '{0, 0, 0,  1, 2, 1, 1, 4};
      tbl[9]  = '{0, 0, 0,  1, 1, 1, 1, 4};
      tbl[10] = '{0, 0, 0,  1, 0, 0, 1, 4};
      tbl[11] = '{0, 0, 0,  1, 0, 0, 1, 4};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_ready", 64'(ready_out), 64'd1);
      chk("rst_count", 64'(count_out), 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      resetn = 1;
      @(negedge clk);

      for (int k = 0; k < 12; k++) begin
         if (k == 4) begin
            chk("full_ready", 64'(ready_out), 64'd0);
            chk("full_af", 64'(almost_full), 64'd1);
            chk("full_lane0", 64'(vector_out[0]), 64'd1);
         end
         if (k >= 8 && k <= 10)
            chk("drain_head", 64'(vector_out[0]), 64'(k - 6));
         if (k == 10) chk("drain_eof", 64'(eof_out), 64'd1);
         cycle(tbl[k].v, tbl[k].e, tbl[k].seed, tbl[k].nx, 1'b0);
         chk("tbl_count", 64'(count_out), 64'(tbl[k].exp_count));
         chk("tbl_valid", 64'(valid_out), 64'(tbl[k].exp_valid));
         chk("tbl_ovf", 64'(overflow), 64'(tbl[k].exp_ovf));
         chk("tbl_drop", 64'(drop_count), 64'(tbl[k].exp_drop));
      end

      // Push into empty, visible the next cycle; then push+pop through pointer wrap.
      cycle(1, 0, 50, 0, 0);
      chk("lat_valid", 64'(valid_out), 64'd1);
      chk("lat_lane0", 64'(vector_out[0]), 64'd50);
      for (int k = 0; k < 20; k++) begin
         cycle(1, k[0], 200 + k, 1, 0);
         chk("pp_count", 64'(count_out), 64'd1);
         chk("pp_lane0", 64'(vector_out[0]), 64'(200 + k));
      end

      // Clear wins over push and pop on the same edge.
      cycle(1, 0, 60, 0, 0);
      chk("pre_clr_count", 64'(count_out), 64'd2);
      cycle(1, 0, 61, 1, 1);
      chk("clr_count", 64'(count_out), 64'd0);
      chk("clr_valid", 64'(valid_out), 64'd0);
      chk("clr_ovf", 64'(overflow), 64'd0);

      // Asynchronous reset between edges with three entries held.
      cycle(1, 0, 70, 0, 0);
      cycle(1, 0, 71, 0, 0);
      cycle(1, 0, 72, 0, 0);
      @(posedge clk);
      #2 resetn = 0;
      #1;
      chk("arst_valid", 64'(valid_out), 64'd0);
      chk("arst_count", 64'(count_out), 64'd0);
      chk("arst_ready", 64'(ready_out), 64'd1);
      model_reset();
      @(negedge clk);
      resetn = 1;
      cycle(1, 1, 77, 0, 0);
      chk("arst_first", 64'(vector_out[0]), 64'd77);
      chk("arst_eof", 64'(eof_out), 64'd1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/input_vector_fifo.md
INPUT_VECTOR_FIFO -- requirements
Module: input_vector_fifo

Interface
REQ-001 SHALL have parameter N, default 8: lanes per vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 SHALL have parameter IB_DEPTH, default 4: entries; power of two, 2..256.
REQ-004 SHALL have parameter AF_LEVEL, default IB_DEPTH-1: almost-full threshold.
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-low, resetn.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 valid_in  input  1  upstream vector present.
REQ-009 eof_in  input  1  end-of-frame tag for vector_in.
REQ-010 vector_in  input  N x DATA_WIDTH  unpacked lane array.
REQ-011 ready_out  output  1  space available (not full).
REQ-012 next_in  input  1  downstream consumes head entry.
REQ-013 clear_in  input  1  synchronous flush.
REQ-014 valid_out  output  1  head entry valid.
REQ-015 eof_out  output  1  eof tag of head entry.
REQ-016 vector_out  output  N x DATA_WIDTH  head entry, lane order preserved.
REQ-017 count_out  output  clog2(IB_DEPTH+1)  current occupancy.
REQ-018 almost_full  output  1  count_out >= AF_LEVEL.
REQ-019 overflow  output  1  sticky: a vector was dropped.
REQ-020 drop_count  output  16  dropped vectors, saturating at 65535.

Function
REQ-021 Push SHALL occur on an edge where valid_in=1 and count<IB_DEPTH; vector and eof stored together at head pointer; head increments modulo IB_DEPTH.
REQ-022 Pop SHALL occur on an edge where next_in=1 and count>0; tail increments modulo IB_DEPTH.
REQ-023 Show-ahead: vector_out/eof_out SHALL reflect the entry at tail combinationally; valid_out = (count>0).
REQ-024 Latency: vector pushed into empty FIFO at edge k SHALL appear with valid_out=1 in the cycle after edge k.
REQ-025 ready_out SHALL equal (count<IB_DEPTH); a push while full is rejected even if a pop occurs the same edge.
REQ-026 Simultaneous push and pop with 0<count<IB_DEPTH SHALL leave count unchanged and both pointers advanced.
REQ-027 next_in while empty SHALL be ignored; push on same edge still proceeds (count 0->1).
REQ-028 valid_in=1 while full SHALL drop the vector, set overflow, increment drop_count (saturating).
REQ-029 clear_in=1 SHALL at the edge zero head, tail, count; overflow and drop_count also cleared; clear_in takes priority over push/pop on the same edge.
REQ-030 Order SHALL be strictly FIFO; eof tags travel with their vector, never reordered.
REQ-031 Pointers SHALL wrap from IB_DEPTH-1 to 0 without data loss.
REQ-032 Storage SHALL be registers without reset; only control state is reset.

Reset
REQ-033 While resetn=0: head=tail=count=0, valid_out=0, ready_out=1, almost_full=0 (unless AF_LEVEL=0), overflow=0, drop_count=0.
REQ-034 Reset asserted mid-operation SHALL discard all content immediately; first valid_in after deassertion stored at entry 0.
REQ-035 Outputs vector_out/eof_out are don't-care while valid_out=0.

Structure
REQ-036 Shared package lb_pkg SHALL hold lane-vector typedef (N x DATA_WIDTH) and drop_count width constant.
REQ-037 One sub-module SHALL be natural: fifo_ctrl (pointers, count, flags); storage array in the top module.

Verification
REQ-038 Reset, push 4 vectors (lane0=1..4, eof on 4th) with next_in=0 -> count_out=4, ready_out=0, almost_full=1.
REQ-039 Full FIFO, valid_in=1 for 3 cycles -> overflow=1, drop_count=3, contents unchanged on drain (1,2,3,4, eof only on 4).
REQ-040 Empty FIFO, push at edge k -> valid_out=1 and vector_out matches in cycle k+1; push+pop every cycle for 20 cycles -> count stays 1, order preserved across wrap.
REQ-041 Count=2, clear_in=1 with valid_in=1 and next_in=1 -> count_out=0, valid_out=0, overflow=0 next cycle.
REQ-042 Count=3, resetn pulsed low asynchronously between edges -> valid_out=0 immediately; next push read back as first entry.
REQ-043 Full FIFO, valid_in=1 and next_in=1 same edge -> pop occurs, push rejected, count=3, drop_count increments by 1.
